// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parameterised single-clock FIFO with standard or first-word-fall-through read
module param_sync_fifo #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] input_data,
  input  logic                 write,
  input  logic                 read,
  output logic [DATA_BITS-1:0] output_data,
  output logic                 output_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                DEPTH    = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] LP_DEPTH = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] LP_AF    = (ADDR_BITS + 1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] LP_AE    = (ADDR_BITS + 1)'(AE_LEVEL);
  localparam logic [ADDR_BITS:0] LP_ONE   = (ADDR_BITS + 1)'(1);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [ADDR_BITS:0]   r_wptr;
  logic [ADDR_BITS:0]   r_rptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_almost_full;
  logic                 r_almost_empty;
  logic                 r_overflow;
  logic                 r_underflow;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_valid;

  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [ADDR_BITS:0]   w_count_next;
  logic [DATA_BITS-1:0] w_head;

  // Accept operations only against the registered flags; reset discards both.
  assign w_wr_en = write && !r_full  && !reset;
  assign w_rd_en = read  && !r_empty && !reset;
  assign w_head  = r_mem[r_rptr[ADDR_BITS-1:0]];

  // Next occupancy from the accepted operations; flags are registered from this value.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_next = r_count + LP_ONE;
      2'b01:   w_count_next = r_count - LP_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Storage is plain memory without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[ADDR_BITS-1:0]] <= input_data;
    end
  end

  // Pointers, occupancy, status flags and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= (AF_LEVEL == 0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + LP_ONE;
      if (w_rd_en) r_rptr <= r_rptr + LP_ONE;
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == LP_DEPTH);
      r_almost_full  <= (w_count_next >= LP_AF);
      r_almost_empty <= (w_count_next <= LP_AE);
      if (write && r_full)  r_overflow  <= 1'b1;
      if (read  && r_empty) r_underflow <= 1'b1;
    end
  end

  // Registered read port: popped word appears one cycle after an accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
      if (w_rd_en) r_out_data <= w_head;
    end
  end

  // In fall-through mode the head entry is shown directly whenever the FIFO holds data.
  assign output_data  = ((FWFT != 0) && !r_empty) ? w_head : r_out_data;
  assign output_valid = (FWFT != 0) ? !r_empty : r_out_valid;

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - scoreboard bench for param_sync_fifo in both read modes
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic       read;
  logic [9:0] din;

  logic [9:0] o0_data, o1_data;
  logic       o0_valid, o1_valid;
  logic       o0_empty, o1_empty, o0_full, o1_full;
  logic       o0_af, o1_af, o0_ae, o1_ae;
  logic [4:0] o0_count, o1_count;
  logic       o0_ovf, o1_ovf, o0_unf, o1_unf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_BITS(10), .ADDR_BITS(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .input_data(din), .write(write), .read(read),
    .output_data(o0_data), .output_valid(o0_valid), .empty(o0_empty), .full(o0_full),
    .almost_full(o0_af), .almost_empty(o0_ae), .count(o0_count),
    .overflow(o0_ovf), .underflow(o0_unf)
  );

  param_sync_fifo #(.DATA_BITS(10), .ADDR_BITS(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .input_data(din), .write(write), .read(read),
    .output_data(o1_data), .output_valid(o1_valid), .empty(o1_empty), .full(o1_full),
    .almost_full(o1_af), .almost_empty(o1_ae), .count(o1_count),
    .overflow(o1_ovf), .underflow(o1_unf)
  );

  // Reference model: FIFO contents as a queue, expected pops as a scoreboard queue.
  logic [9:0] mq[$];
  logic [9:0] expq[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  bit         m_oval = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      expq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_oval = 1'b0;
    end else begin
      bit wr_ok;
      bit rd_ok;
      wr_ok = write && (mq.size() < 16);
      rd_ok = read && (mq.size() > 0);
      if (write && !wr_ok) m_ovf = 1'b1;
      if (read && !rd_ok)  m_unf = 1'b1;
      m_oval = rd_ok;
      if (rd_ok) expq.push_back(mq.pop_front());
      if (wr_ok) mq.push_back(din);
    end
  end

  // Monitor: compares every status output each cycle, pops the scoreboard on output_valid.
  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("count0", 32'(o0_count), 32'(n));
    chk("empty0", 32'(o0_empty), 32'(n == 0));
    chk("full0",  32'(o0_full),  32'(n == 16));
    chk("af0",    32'(o0_af),    32'(n >= 12));
    chk("ae0",    32'(o0_ae),    32'(n <= 2));
    chk("ovf0",   32'(o0_ovf),   32'(m_ovf));
    chk("unf0",   32'(o0_unf),   32'(m_unf));
    chk("valid0", 32'(o0_valid), 32'(m_oval));
    if (o0_valid === 1'b1) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL data0: output_valid with no expected word at %0t", $time);
      end else begin
        chk("data0", 32'(o0_data), 32'(expq.pop_front()));
      end
    end
    chk("count1", 32'(o1_count), 32'(n));
    chk("empty1", 32'(o1_empty), 32'(n == 0));
    chk("full1",  32'(o1_full),  32'(n == 16));
    chk("ovf1",   32'(o1_ovf),   32'(m_ovf));
    chk("unf1",   32'(o1_unf),   32'(m_unf));
    chk("valid1", 32'(o1_valid), 32'(n != 0));
    if (n != 0) chk("data1", 32'(o1_data), 32'(mq[0]));
  end

  task automatic drive(input bit rst, input bit w, input bit r, input logic [9:0] d);
    reset = rst;
    write = w;
    read  = r;
    din   = d;
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 10'h0);
    drive(1'b1, 1'b1, 1'b1, 10'h3C3);
    chk("rst_data0", 32'(o0_data), 32'h0);
    chk("rst_data1", 32'(o1_data), 32'h0);
    chk("rst_af0",   32'(o0_af),   32'h0);

    // Fill 0x001..0x010, then a rejected write while full.
    for (int i = 1; i <= 16; i++) drive(1'b0, 1'b1, 1'b0, 10'(i));
    chk("fill_full", 32'(o0_full), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 10'h3FF);
    chk("ovf_set", 32'(o0_ovf), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 10'h0);
    chk("ovf_sticky", 32'(o0_ovf), 32'h1);

    // Drain plus one extra read for underflow.
    for (int i = 0; i < 17; i++) drive(1'b0, 1'b0, 1'b1, 10'h0);
    drive(1'b0, 1'b0, 1'b0, 10'h0);
    chk("drain_empty", 32'(o0_empty), 32'h1);
    chk("unf_set", 32'(o0_unf), 32'h1);

    // Hold at 8 entries with simultaneous operations across pointer wrap.
    drive(1'b1, 1'b0, 1'b0, 10'h0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 10'($urandom));
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b1, 10'($urandom));
    chk("wrap_count", 32'(o0_count), 32'd8);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 10'h0);

    // Random traffic: write-heavy, read-heavy, then balanced.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 200; i++) begin
        int wp;
        int rp;
        wp = (p == 0) ? 80 : (p == 1) ? 20 : 50;
        rp = 100 - wp;
        drive(1'b0, ($urandom_range(99) < wp), ($urandom_range(99) < rp), 10'($urandom));
      end
    end

    // Fall-through visibility of a single word.
    drive(1'b1, 1'b0, 1'b0, 10'h0);
    drive(1'b0, 1'b1, 1'b0, 10'h155);
    chk("fwft_data", 32'(o1_data), 32'h155);
    chk("fwft_valid", 32'(o1_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 10'h0);
    chk("fwft_valid_off", 32'(o1_valid), 32'h0);
    chk("fwft_empty", 32'(o1_empty), 32'h1);

    // Reset mid-stream with concurrent write and read.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 10'(i + 32));
    drive(1'b1, 1'b1, 1'b1, 10'h2EE);
    chk("mid_rst_count", 32'(o0_count), 32'h0);
    chk("mid_rst_empty", 32'(o0_empty), 32'h1);
    chk("mid_rst_ae", 32'(o0_ae), 32'h1);
    chk("mid_rst_data", 32'(o0_data), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 10'h0AA);
    drive(1'b0, 1'b0, 1'b1, 10'h0);
    chk("post_rst_data", 32'(o0_data), 32'h0AA);
    chk("post_rst_valid", 32'(o0_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 10'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_BITS, default 10, width of input_data and output_data.
REQ-002 Parameter ADDR_BITS, default 4, storage depth DEPTH = 2**ADDR_BITS entries.
REQ-003 Parameter AF_LEVEL, default 12, almost_full threshold; legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0, selects the read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 Port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1 bit, synchronous, active-high reset.
REQ-008 Port input_data, input, DATA_BITS bits, write data.
REQ-009 Port write, input, 1 bit, write request.
REQ-010 Port read, input, 1 bit, read request (pop).
REQ-011 Port output_data, output, DATA_BITS bits, read data.
REQ-012 Port output_valid, output, 1 bit, output_data holds a valid popped or head word.
REQ-013 Port empty, output, 1 bit, count == 0.
REQ-014 Port full, output, 1 bit, count == DEPTH.
REQ-015 Port almost_full, output, 1 bit, count >= AF_LEVEL.
REQ-016 Port almost_empty, output, 1 bit, count <= AE_LEVEL.
REQ-017 Port count, output, ADDR_BITS+1 bits, current occupancy, 0..DEPTH.
REQ-018 Port overflow, output, 1 bit, sticky flag: a write was rejected.
REQ-019 Port underflow, output, 1 bit, sticky flag: a read was rejected.

Function
REQ-020 A write SHALL be accepted iff write && !full, storing input_data at the write pointer and advancing it by one.
REQ-021 A read SHALL be accepted iff read && !empty, advancing the read pointer by one.
REQ-022 Pointers SHALL be ADDR_BITS+1 bits wide, wrap modulo 2*DEPTH, and address storage with their low ADDR_BITS bits.
REQ-023 count SHALL update on the same edge as the accepted operations: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 empty, full, almost_full and almost_empty SHALL be registered and consistent with the registered count in every cycle.
REQ-025 When full, a simultaneous write and read SHALL accept the read, reject the write and set overflow.
REQ-026 When empty, a simultaneous write and read SHALL accept the write, reject the read and set underflow.
REQ-027 overflow SHALL set on write && full and underflow on read && empty; both SHALL hold until reset.
REQ-028 When FWFT=0, an accepted read SHALL present the popped word on output_data with output_valid=1 on the next cycle (latency 1); otherwise output_valid=0 and output_data holds its last value.
REQ-029 When FWFT=1, output_data SHALL show the head entry and output_valid SHALL equal !empty; a write into an empty FIFO SHALL become visible on the cycle after the write edge.
REQ-030 When FWFT=1, read SHALL pop the currently shown word; the next entry (or output_valid=0) SHALL appear on the following cycle.
REQ-031 Storage SHALL be inferred memory that is not reset; rejected operations SHALL not modify storage, pointers or count.

Reset
REQ-032 While reset=1 at a clk edge, pointers SHALL clear to 0 and outputs SHALL become: count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=0, underflow=0, output_valid=0, output_data=0.
REQ-033 Reset SHALL take priority over concurrent write and read; such operations SHALL be discarded.
REQ-034 Reset asserted mid-operation SHALL discard all stored entries; the first post-reset write SHALL be the first word read.

Verification
REQ-035 Fill: defaults, FWFT=0, write 0x001..0x010 on 16 consecutive cycles -> count=16, full=1, almost_full from count=12, overflow=0.
REQ-036 Overflow: full, assert write with 0x3FF -> write rejected, overflow=1 and sticky, count stays 16, later read order still 0x001..0x010.
REQ-037 Drain and latency: from full, FWFT=0, read on 16 cycles -> output_data 0x001..0x010 each one cycle after its read with output_valid=1, empty=1 at end; one more read -> underflow=1.
REQ-038 Wrap plus simultaneous operations: 40 cycles with write and read both asserted at count=8 -> count constant 8, data in order across pointer wrap, no flag changes.
REQ-039 FWFT: FWFT=1, write 0x155 into an empty FIFO -> next cycle output_data=0x155, output_valid=1; read -> following cycle output_valid=0, empty=1.
REQ-040 Reset mid-stream: count=5, assert reset concurrently with write and read -> all REQ-032 values next cycle; write 0x0AA then read -> 0x0AA returned.
